// File: rtl/aq_gemac_rx_reader.sv
`default_nettype none
// ============================================================================
//  Module      : aq_gemac_rx_reader
//  Description : User-side reader for the aq_gemac RX buffer. Pops complete
//                frames word by word in the system clock domain. Good frames
//                are forwarded as a framed 32-bit ready/valid stream through
//                a 2-entry skid FIFO. Frames with error status or an illegal
//                length are drained from the buffer and discarded.
//  Optional    : AQ_GEMAC_RX_READER_STATS_EN
//                  defined   -> frame_cnt_o / drop_cnt_o are saturating
//                               16-bit counters
//                  undefined -> both counters tied to zero, no registers
//  Ports       : clk, rst_n         clock, asynchronous active-low reset
//                rx_buff_re_o       pop one word from the RX buffer
//                rx_buff_data_i     pop data, valid the cycle after RE
//                rx_buff_empty_i    no word available
//                rx_buff_valid_i    head-frame header valid
//                rx_buff_length_i   head-frame length in bytes
//                rx_buff_status_i   head-frame status
//                out_data_o         stream data, byte 0 in [7:0]
//                out_valid_o        stream word valid
//                out_ready_i        sink accepts on valid & ready
//                out_start_o        first word of frame
//                out_end_o          last word of frame
//                out_bytes_o        valid bytes on END word (0 = 4)
//                frame_cnt_o        good frames forwarded (saturating)
//                drop_cnt_o         frames dropped (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module aq_gemac_rx_reader #(
  parameter logic [15:0] DROP_MASK = 16'h00FF,
  parameter logic [15:0] MAX_LEN   = 16'd1522,
  parameter logic [15:0] MIN_LEN   = 16'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rx_buff_re_o,
  input  logic [31:0] rx_buff_data_i,
  input  logic        rx_buff_empty_i,
  input  logic        rx_buff_valid_i,
  input  logic [15:0] rx_buff_length_i,
  input  logic [15:0] rx_buff_status_i,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_start_o,
  output logic        out_end_o,
  output logic [1:0]  out_bytes_o,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] drop_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HEAD = 3'd1,
    ST_READ = 3'd2,
    ST_WAIT = 3'd3,
    ST_DROP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] remain_q, remain_d;     // words still to pop for this frame
  logic [1:0]  bytes_q, bytes_d;       // LENGTH[1:0] of the current frame
  logic        first_q, first_d;       // next READ pop is the frame's first word

  // Pop issued last cycle in READ; its data lands on rx_buff_data_i now.
  logic        pend_q, pend_d;
  logic        pend_start_q, pend_start_d;
  logic        pend_end_q, pend_end_d;

  // Skid FIFO storage: data plus {start, end, bytes}.
  logic [31:0] fifo_data_q [2];
  logic [3:0]  fifo_ctl_q  [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  cnt_q;

  logic [15:0] w_nwords;
  logic        w_drop;
  logic        w_push;
  logic        w_pop;
  logic [2:0]  w_occ;
  logic        w_room;
  logic        w_re;
  logic        w_frame_inc;
  logic        w_drop_inc;

  // --------------------------------------------------------------------------
  // Header decode
  // --------------------------------------------------------------------------
  // A zero-length frame still occupies one buffer word.
  assign w_nwords = (rx_buff_length_i == 16'd0) ? 16'd1
                                                : ((rx_buff_length_i + 16'd3) >> 2);

  assign w_drop = (|(rx_buff_status_i & DROP_MASK))
                | (rx_buff_length_i < MIN_LEN)
                | (rx_buff_length_i > MAX_LEN);

  // --------------------------------------------------------------------------
  // FIFO flow control
  // --------------------------------------------------------------------------
  assign out_valid_o = (cnt_q != 2'd0);
  assign w_pop       = out_valid_o & out_ready_i;
  assign w_push      = pend_q;

  // Occupancy counts the word already in flight. A pop in this same cycle
  // frees a slot, which is what lets the reader sustain one word per cycle
  // instead of stalling every third cycle when the FIFO sits at one entry.
  assign w_occ  = {1'b0, cnt_q} + {2'b00, pend_q};
  assign w_room = (w_occ < (3'd2 + {2'b00, w_pop}));

  assign rx_buff_re_o = w_re;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      remain_q     <= 16'd0;
      bytes_q      <= 2'b00;
      first_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_start_q <= 1'b0;
      pend_end_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      remain_q     <= remain_d;
      bytes_q      <= bytes_d;
      first_q      <= first_d;
      pend_q       <= pend_d;
      pend_start_q <= pend_start_d;
      pend_end_q   <= pend_end_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    remain_d     = remain_q;
    bytes_d      = bytes_q;
    first_d      = first_q;
    pend_d       = 1'b0;
    pend_start_d = 1'b0;
    pend_end_d   = 1'b0;
    w_re         = 1'b0;
    w_frame_inc  = 1'b0;
    w_drop_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_buff_valid_i) begin
          state_d = ST_HEAD;
        end
      end

      ST_HEAD: begin
        remain_d = w_nwords;
        bytes_d  = rx_buff_length_i[1:0];
        first_d  = 1'b1;
        state_d  = w_drop ? ST_DROP : ST_READ;
      end

      ST_READ: begin
        if (!rx_buff_empty_i && w_room) begin
          w_re         = 1'b1;
          pend_d       = 1'b1;
          pend_start_d = first_q;
          pend_end_d   = (remain_q == 16'd1);
          first_d      = 1'b0;
          remain_d     = remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            state_d = ST_WAIT;
          end
        end
      end

      // Entered straight after the last pop, so the pending word here is
      // always the frame's END word being written into the FIFO.
      ST_WAIT: begin
        if (pend_q) begin
          w_frame_inc = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      ST_DROP: begin
        if (!rx_buff_empty_i) begin
          w_re     = 1'b1;
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            w_drop_inc = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Skid FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= 32'd0;
        fifo_ctl_q[i]  <= 4'd0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (w_push) begin
        fifo_data_q[wr_ptr_q] <= rx_buff_data_i;
        fifo_ctl_q[wr_ptr_q]  <= {pend_start_q, pend_end_q,
                                  (pend_end_q ? bytes_q : 2'b00)};
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign out_data_o = fifo_data_q[rd_ptr_q];
  assign {out_start_o, out_end_o, out_bytes_o} = fifo_ctl_q[rd_ptr_q];

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef AQ_GEMAC_RX_READER_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      if (w_frame_inc && (frame_cnt_q != 16'hFFFF)) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (w_drop_inc && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_frame_inc | w_drop_inc;
  assign frame_cnt_o    = 16'h0000;
  assign drop_cnt_o     = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aq_gemac_rx_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aq_gemac_rx_reader
//  Description : Randomised scoreboard bench for aq_gemac_rx_reader with a
//                behavioural RX buffer model and frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aq_gemac_rx_reader;

  localparam int MAX_CYC = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_buff_re_o;
  logic [31:0] rx_buff_data_i = 32'd0;
  logic        rx_buff_empty_i = 1'b1;
  logic        rx_buff_valid_i = 1'b0;
  logic [15:0] rx_buff_length_i = 16'd0;
  logic [15:0] rx_buff_status_i = 16'd0;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic        out_start_o;
  logic        out_end_o;
  logic [1:0]  out_bytes_o;
  logic [15:0] frame_cnt_o;
  logic [15:0] drop_cnt_o;

  aq_gemac_rx_reader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx_buff_re_o     (rx_buff_re_o),
    .rx_buff_data_i   (rx_buff_data_i),
    .rx_buff_empty_i  (rx_buff_empty_i),
    .rx_buff_valid_i  (rx_buff_valid_i),
    .rx_buff_length_i (rx_buff_length_i),
    .rx_buff_status_i (rx_buff_status_i),
    .out_data_o       (out_data_o),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_start_o      (out_start_o),
    .out_end_o        (out_end_o),
    .out_bytes_o      (out_bytes_o),
    .frame_cnt_o      (frame_cnt_o),
    .drop_cnt_o       (drop_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // RX buffer model: frame headers and a flat word store.
  int          fq_len[$];
  int          fq_status[$];
  logic [31:0] bw[$];
  int          ptr = 0;
  int          gap = 0;
  logic        re_prev = 1'b0;
  int          pops = 0;
  int          ready_mode = 0;   // 0: always 1, 1: toggle, 2: random
  bit          stall_en = 1'b0;

  // Reference model: expected {data, start, end, bytes} and frame counts.
  logic [35:0] exp_q[$];
  int          model_good = 0;
  int          model_drop = 0;

  // Monitor bookkeeping.
  logic [35:0] got;
  logic [35:0] held;
  logic [35:0] e;
  bit          stalled = 1'b0;
  int          acc_in_frame = 0;
  int          start_cyc = 0;
  int          end_cyc = 0;

  function automatic int nwords_of(input int len);
    return (len == 0) ? 1 : (len + 3) / 4;
  endfunction

  function automatic bit is_drop(input int len, input int st);
    return ((st & 32'h0000_00FF) != 0) || (len < 1) || (len > 1522);
  endfunction

  task automatic send_frame(input int len, input int st);
    int          nw;
    bit          drp;
    logic [31:0] w;
    logic [1:0]  b;
    nw  = nwords_of(len);
    drp = is_drop(len, st);
    b   = 2'(len % 4);
    for (int i = 0; i < nw; i++) begin
      w = $urandom;
      bw.push_back(w);
      if (!drp) exp_q.push_back({w, (i == 0), (i == nw - 1), ((i == nw - 1) ? b : 2'b00)});
    end
    fq_len.push_back(len);
    fq_status.push_back(st);
    if (drp) model_drop++;
    else     model_good++;
  endtask

  // --------------------------------------------------------------------------
  // RX buffer model and sink ready driver
  // --------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (re_prev) begin
        if (bw.size() > 0) rx_buff_data_i = bw.pop_front();
        pops++;
        ptr++;
        if (fq_len.size() > 0 && ptr >= nwords_of(fq_len[0])) begin
          void'(fq_len.pop_front());
          void'(fq_status.pop_front());
          ptr = 0;
          gap = $urandom_range(0, 2);
        end
      end else if (gap > 0) begin
        gap--;
      end
      if (fq_len.size() > 0 && gap == 0) begin
        rx_buff_valid_i  = 1'b1;
        rx_buff_length_i = 16'(fq_len[0]);
        rx_buff_status_i = 16'(fq_status[0]);
        rx_buff_empty_i  = (ptr >= nwords_of(fq_len[0])) ||
                           (stall_en && ($urandom_range(0, 3) == 0));
      end else begin
        rx_buff_valid_i  = 1'b0;
        rx_buff_length_i = 16'd0;
        rx_buff_status_i = 16'd0;
        rx_buff_empty_i  = 1'b1;
      end
      case (ready_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = ~out_ready_i;
        default: out_ready_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      re_prev = rx_buff_re_o;
      if (re_prev) begin
        checks++;
        if (rx_buff_empty_i) begin
          errors++;
          $display("FAIL re_while_empty re=%0b empty=%0b required empty=0 at cycle %0d",
                   re_prev, rx_buff_empty_i, cyc);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output monitor / scoreboard
  // --------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      got = {out_data_o, out_start_o, out_end_o, out_bytes_o};
      if (!rst_n || !out_valid_o) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checks++;
          if (got !== held) begin
            errors++;
            $display("FAIL hold_stable got %h required %h at cycle %0d", got, held, cyc);
          end
        end
        if (out_ready_i) begin
          stalled = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word got %h required none at cycle %0d", got, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e[2] ? (got !== e) : (got[35:2] !== e[35:2])) begin
              errors++;
              $display("FAIL out_word got %h required %h at cycle %0d", got, e, cyc);
            end
          end
          if (out_start_o) begin
            acc_in_frame = 1;
            start_cyc    = cyc;
          end else begin
            acc_in_frame++;
          end
          if (out_end_o) end_cyc = cyc;
        end else begin
          stalled = 1'b1;
          held    = got;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((fq_len.size() > 0 || exp_q.size() > 0) && n < MAX_CYC) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= MAX_CYC) begin
      errors++;
      $display("FAIL %s_timeout frames_left %0d words_left %0d required 0", name,
               fq_len.size(), exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_counters(input string name);
    int efc, edc;
`ifdef AQ_GEMAC_RX_READER_STATS_EN
    efc = (model_good > 65535) ? 65535 : model_good;
    edc = (model_drop > 65535) ? 65535 : model_drop;
`else
    efc = 0;
    edc = 0;
`endif
    checks++;
    if (int'(frame_cnt_o) != efc) begin
      errors++;
      $display("FAIL %s_frame_cnt got %0d required %0d", name, frame_cnt_o, efc);
    end
    checks++;
    if (int'(drop_cnt_o) != edc) begin
      errors++;
      $display("FAIL %s_drop_cnt got %0d required %0d", name, drop_cnt_o, edc);
    end
  endtask

  task automatic check_pops(input string name, input int req);
    checks++;
    if (pops != req) begin
      errors++;
      $display("FAIL %s_pops got %0d required %0d", name, pops, req);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [89:0] v;
    v = {rx_buff_re_o, out_data_o, out_valid_o, out_start_o, out_end_o, out_bytes_o,
         frame_cnt_o, drop_cnt_o};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s_outputs got %h required 0", name, v);
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int n;
    int l, s, r, req;

    #3;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 64-byte good frame, no stalls: 16 back-to-back words.
    ready_mode = 0; stall_en = 1'b0; pops = 0;
    send_frame(64, 0);
    drain("f64");
    check_pops("f64", 16);
    checks++;
    if (end_cyc - start_cyc != 15) begin
      errors++;
      $display("FAIL f64_burst span got %0d required 15", end_cyc - start_cyc);
    end
    check_counters("f64");

    // 61-byte frame then 1-byte frame.
    pops = 0;
    send_frame(61, 0);
    send_frame(1, 0);
    drain("f61_f1");
    check_pops("f61_f1", 17);
    check_counters("f61_f1");

    // Error-status frame dropped, then a good frame.
    pops = 0;
    send_frame(64, 16'h0001);
    send_frame(64, 0);
    drain("errdrop");
    check_pops("errdrop", 32);
    check_counters("errdrop");

    // Alternating ready.
    ready_mode = 1; pops = 0;
    send_frame(64, 0);
    drain("toggle");
    check_pops("toggle", 16);
    check_counters("toggle");

    // Illegal lengths.
    ready_mode = 0; pops = 0;
    send_frame(1600, 0);
    send_frame(0, 0);
    drain("badlen");
    check_pops("badlen", 401);
    check_counters("badlen");

    // Randomised traffic with buffer stalls and random backpressure.
    ready_mode = 2; stall_en = 1'b1; pops = 0; req = 0;
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      s = 0;
      if (r == 0)      l = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1523, 1700);
      else             l = $urandom_range(1, 120);
      if (r == 1)      s = $urandom_range(1, 255) | ($urandom_range(0, 255) << 8);
      else if (r == 2) s = $urandom_range(1, 255) << 8;
      req += nwords_of(l);
      send_frame(l, s);
    end
    drain("random");
    check_pops("random", req);
    check_counters("random");

    // Reset in the middle of a frame.
    ready_mode = 0; stall_en = 1'b0;
    send_frame(64, 0);
    n = 0;
    while (acc_in_frame < 8 && n < MAX_CYC) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= MAX_CYC) begin
      errors++;
      $display("FAIL midreset_wait words %0d required 8", acc_in_frame);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    fq_len.delete();
    fq_status.delete();
    bw.delete();
    exp_q.delete();
    ptr = 0; gap = 0; re_prev = 1'b0; acc_in_frame = 0;
    model_good = 0; model_drop = 0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    pops = 0;
    send_frame(64, 0);
    drain("postreset");
    check_pops("postreset", 16);
    check_counters("postreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aq_gemac_rx_reader.md
Name: aq_gemac_rx_reader

Overview:
User-side reader for the RX buffer interface of aq_gemac. It runs in the system clock domain and pops complete frames word-by-word from the RX buffer. Good frames are forwarded as a framed 32-bit stream with start/end/valid-byte markers and ready/valid backpressure. Frames with error status or an illegal length are drained and discarded.

Parameters:
DROP_MASK, 16'h00FF, RX_BUFF_STATUS bits that cause a drop when any is set
MAX_LEN, 16'd1522, largest accepted frame length in bytes; longer frames are dropped
MIN_LEN, 16'd1, smallest accepted frame length in bytes; shorter frames are dropped

Ports:
CLK  in  1  system clock
RST_N  in  1  reset (asynchronous, active-low)
RX_BUFF_RE  out  1  pop one word from RX buffer
RX_BUFF_DATA  in  32  RX buffer read data; valid 1 cycle after RE
RX_BUFF_EMPTY  in  1  no word available
RX_BUFF_VALID  in  1  header of the head frame is valid
RX_BUFF_LENGTH  in  16  head-frame length in bytes
RX_BUFF_STATUS  in  16  head-frame status
OUT_DATA  out  32  stream data, byte 0 in [7:0]
OUT_VALID  out  1  OUT_* valid
OUT_READY  in  1  sink accepts word when OUT_VALID&OUT_READY
OUT_START  out  1  first word of frame
OUT_END  out  1  last word of frame
OUT_BYTES  out  2  valid bytes on END word (0 = 4)
FRAME_CNT  out  16  good frames forwarded, saturating
DROP_CNT  out  16  frames dropped, saturating

Behaviour:
- Clock and reset: one clock (CLK). RST_N is asynchronous, active-low, as fixed for this block.
- Reset values: all outputs 0. FSM in IDLE. Skid FIFO empty. Counters 0.
- RX buffer contract:
  - Header (VALID/LENGTH/STATUS) is stable from VALID rising until the frame's last word is popped.
  - RE only when !EMPTY; data appears on RX_BUFF_DATA the next cycle.
  - RE is never asserted while EMPTY=1.
- Word count: nwords = (LENGTH+3)>>2, computed 16-bit, no overflow for LENGTH ≤ 16'hFFFC. LENGTH = 0 is treated as nwords = 1.
- Drop decision, latched in HEAD: drop = |(STATUS & DROP_MASK) | (LENGTH < MIN_LEN) | (LENGTH > MAX_LEN).
- FSM:
  - IDLE: if RX_BUFF_VALID → HEAD.
  - HEAD (1 cycle): latch nwords, LENGTH[1:0], drop → READ if !drop, else DROP.
  - READ: assert RE when !EMPTY and (fifo_count + inflight) < 2; decrement remaining count on each RE. When the last RE is issued → WAIT.
  - DROP: assert RE whenever !EMPTY; no FIFO writes. On the last RE, DROP_CNT+1 and go to IDLE.
  - WAIT: once the last word is written to the FIFO, FRAME_CNT+1 → IDLE. A new header is not accepted before WAIT completes; the FIFO may still drain.
- Skid FIFO: 2 entries holding {data, start, end, bytes}.
  - Write on the cycle after a READ-state RE.
  - The first word of a frame carries start=1. The last word carries end=1 and bytes = LENGTH[1:0].
  - A single-word frame has START and END both 1.
- Output: OUT_* is the FIFO head. OUT_VALID = FIFO non-empty. Pop on OUT_VALID & OUT_READY.
  - Simultaneous push and pop with 2 entries is legal; count is unchanged.
  - Data ordering is strict; no bubbles are inserted when READY stays high and EMPTY stays low. Sustained rate is 1 word/cycle.
- OUT_DATA, START, END and BYTES hold stable while OUT_VALID=1 and OUT_READY=0.
- Counters saturate at 16'hFFFF.
- Reset mid-frame: state is cleared immediately. The RX buffer shares RST_N, so no resynchronisation is needed.

Optional Feature:
AQ_GEMAC_RX_READER_STATS_EN
- Defined: FRAME_CNT and DROP_CNT are implemented as above.
- Undefined: both counters are tied to 16'h0000 and their registers are removed. Data path behaviour is identical.

Test Plan:
- 64-byte frame, STATUS=0, OUT_READY=1, EMPTY low throughout → 16 OUT words on 16 consecutive cycles. START on word 0; END with BYTES=0 on word 15. FRAME_CNT=1.
- 61-byte frame → 16 words; END word BYTES=1. Then a 1-byte frame → a single word with START=END=1, BYTES=1. FRAME_CNT=2.
- 64-byte frame with STATUS=16'h0001 → 16 REs issued, OUT_VALID never 1, DROP_CNT=1. A following good frame is then forwarded intact.
- 64-byte frame with OUT_READY toggled 1/0 every cycle → exactly 16 accepted words, in order with no loss or duplication. Data held stable while stalled. FIFO never exceeds 2 entries.
- LENGTH=1600 and LENGTH=0 frames → both dropped, DROP_CNT=2. 400 and 1 REs issued respectively.
- RST_N pulsed low at word 8 of a 64-byte frame → all outputs 0 asynchronously. After release, a fresh 64-byte frame is forwarded correctly.
